// File: rtl/adder_scheduler_pkg.sv
// Shared types and helpers for the adder scheduler slice.
package adder_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;

  // Requester id width; a single-bit id is kept even for two requesters.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_scheduler_if.sv
// Requester, adder and response signals shared by the scheduler and its parent.
interface adder_scheduler_if
  import adder_scheduler_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REQUESTERS = 4
);
  localparam int ID_WIDTH = id_width(REQUESTERS);

  logic [REQUESTERS-1:0]            req_valid;
  logic [REQUESTERS-1:0]            req_ready;
  logic [REQUESTERS-1:0][WIDTH-1:0] req_value_a;
  logic [REQUESTERS-1:0][WIDTH-1:0] req_value_b;
  logic [WIDTH-1:0]                 adder_value_a;
  logic [WIDTH-1:0]                 adder_value_b;
  logic [WIDTH-1:0]                 adder_sum;
  logic                             adder_overflow;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [ID_WIDTH-1:0]              rsp_id;
  logic [WIDTH-1:0]                 rsp_sum;
  logic                             rsp_overflow;

  modport slave (
    input  req_valid, req_value_a, req_value_b, adder_sum, adder_overflow, rsp_ready,
    output req_ready, adder_value_a, adder_value_b, rsp_valid, rsp_id, rsp_sum, rsp_overflow
  );

  modport master (
    output req_valid, req_value_a, req_value_b, adder_sum, adder_overflow, rsp_ready,
    input  req_ready, adder_value_a, adder_value_b, rsp_valid, rsp_id, rsp_sum, rsp_overflow
  );

endinterface

// File: rtl/adder_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request strictly after the last winner.
module rr_arbiter
  import adder_scheduler_pkg::*;
#(
  parameter  int REQUESTERS = 4,
  localparam int IDW        = id_width(REQUESTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTERS-1:0] request,
  input  logic                  advance,
  output logic [REQUESTERS-1:0] grant,
  output logic [IDW-1:0]        grant_id
);

  logic [IDW-1:0] last_grant;

  always_ff @(posedge clk) begin
    if (rst)          last_grant <= IDW'(REQUESTERS - 1);
    else if (advance) last_grant <= grant_id;
  end

  // Scan from farthest to nearest so the nearest request overrides.
  always_comb begin
    int             idx;
    logic [IDW-1:0] sel;
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    sel      = '0;
    for (int k = REQUESTERS; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      sel = IDW'(idx);
      if (request[sel]) begin
        grant      = '0;
        grant[sel] = 1'b1;
        grant_id   = sel;
      end
    end
  end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one external adder between requesters, one operation in flight.
module adder_scheduler
  import adder_scheduler_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int REQUESTERS    = 4,
  parameter int ADDER_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  adder_scheduler_if.slave  bus
);

  localparam int IDW   = id_width(REQUESTERS);
  localparam int CNT_W = (ADDER_LATENCY < 2) ? 1 : $clog2(ADDER_LATENCY);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [REQUESTERS-1:0] grant;
  logic [IDW-1:0]        grant_id;
  logic                  accept;
  logic [WIDTH-1:0]      op_a_q, op_b_q, sum_q;
  logic [IDW-1:0]        id_q;
  logic                  ovf_q;

  // Grant is only live in IDLE, so any grant there is a handshake.
  assign accept = (state_q == IDLE) && (|grant);

  rr_arbiter #(.REQUESTERS(REQUESTERS)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .request  (bus.req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESPOND;
      RESPOND: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a_q <= bus.req_value_a[grant_id];
        op_b_q <= bus.req_value_b[grant_id];
        id_q   <= grant_id;
      end
      if (state_q == ISSUE)
        cnt_q <= CNT_W'(ADDER_LATENCY - 1);
      else if (state_q == WAIT && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
      if (state_q == WAIT && cnt_q == '0) begin
        sum_q <= bus.adder_sum;
        ovf_q <= bus.adder_overflow;
      end
    end
  end

  assign bus.req_ready     = (state_q == IDLE) ? grant : '0;
  assign bus.adder_value_a = op_a_q;
  assign bus.adder_value_b = op_b_q;
  assign bus.rsp_valid     = (state_q == RESPOND);
  assign bus.rsp_id        = id_q;
  assign bus.rsp_sum       = sum_q;
  assign bus.rsp_overflow  = ovf_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed bench for adder_scheduler with latency-1 and latency-3 adder models.
module tb_adder_scheduler;
  localparam int W = 32;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_scheduler_if #(.WIDTH(W), .REQUESTERS(R)) bif  ();
  adder_scheduler_if #(.WIDTH(W), .REQUESTERS(R)) bif3 ();

  adder_scheduler #(.WIDTH(W), .REQUESTERS(R), .ADDER_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bif.slave));
  adder_scheduler #(.WIDTH(W), .REQUESTERS(R), .ADDER_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bif3.slave));

  // Adder models: one registered stage, and three registered stages.
  always_ff @(posedge clk)
    {bif.adder_overflow, bif.adder_sum} <= {1'b0, bif.adder_value_a} + {1'b0, bif.adder_value_b};

  logic [W:0] d3 [3];
  always_ff @(posedge clk) begin
    d3[0] <= {1'b0, bif3.adder_value_a} + {1'b0, bif3.adder_value_b};
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign {bif3.adder_overflow, bif3.adder_sum} = d3[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [R-1:0] onehot(input logic [1:0] id);
    logic [R-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Single-requester operation with rsp_ready held high, strict cycle timing.
  task automatic run_op(input string tag, input logic [1:0] id, input logic [W-1:0] a, b,
                        input logic [W-1:0] esum, input logic eovf);
    bif.req_value_a[id] = a;
    bif.req_value_b[id] = b;
    bif.req_valid       = onehot(id);
    #1 chk({tag, "_grant"}, bif.req_ready, onehot(id));
    tick();
    bif.req_valid = '0;
    chk({tag, "_op_a"}, bif.adder_value_a, a);
    chk({tag, "_op_b"}, bif.adder_value_b, b);
    chk({tag, "_ready_busy"}, bif.req_ready, '0);
    tick();
    chk({tag, "_early_valid"}, bif.rsp_valid, 0);
    tick();
    chk({tag, "_rsp_valid"}, bif.rsp_valid, 1);
    chk({tag, "_rsp_id"}, bif.rsp_id, id);
    chk({tag, "_rsp_sum"}, bif.rsp_sum, esum);
    chk({tag, "_rsp_ovf"}, bif.rsp_overflow, eovf);
    tick();
    chk({tag, "_idle"}, bif.rsp_valid, 0);
  endtask

  initial begin
    int cyc;
    bif.req_valid    = '0;
    bif.req_value_a  = '0;
    bif.req_value_b  = '0;
    bif.rsp_ready    = 1'b1;
    bif3.req_valid   = '0;
    bif3.req_value_a = '0;
    bif3.req_value_b = '0;
    bif3.rsp_ready   = 1'b1;

    rst = 1'b1;
    tick(); tick();
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_rsp_id",    bif.rsp_id, 0);
    chk("rst_rsp_sum",   bif.rsp_sum, 0);
    chk("rst_op_a",      bif.adder_value_a, 0);
    chk("rst_req_ready", bif.req_ready, '0);
    rst = 1'b0;

    run_op("single", 2'd0, 32'd5, 32'd7, 32'd12, 1'b0);
    run_op("ovf",    2'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    run_op("ovf_hi", 2'd3, 32'h8000_0000, 32'h8000_0001, 32'd1, 1'b1);
    run_op("mix",    2'd1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);

    // Backpressure: response from req3 held while req1 waits.
    bif.rsp_ready      = 1'b0;
    bif.req_value_a[3] = 32'd3;
    bif.req_value_b[3] = 32'd4;
    bif.req_valid      = 4'b1000;
    #1 chk("bp_grant3", bif.req_ready, 4'b1000);
    tick();
    bif.req_value_a[1] = 32'd20;
    bif.req_value_b[1] = 32'd22;
    bif.req_valid      = 4'b0010;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", bif.rsp_valid, 1);
      chk("bp_hold_id",    bif.rsp_id, 3);
      chk("bp_hold_sum",   bif.rsp_sum, 7);
      chk("bp_hold_ready", bif.req_ready, '0);
      chk("bp_hold_op_a",  bif.adder_value_a, 3);
      tick();
    end
    bif.rsp_ready = 1'b1;
    #1 chk("bp_ready_still0", bif.req_ready, '0);
    tick();
    chk("bp_grant1", bif.req_ready, 4'b0010);
    chk("bp_released", bif.rsp_valid, 0);
    tick();
    bif.req_valid = '0;
    tick(); tick();
    chk("bp_rsp1_valid", bif.rsp_valid, 1);
    chk("bp_rsp1_id",    bif.rsp_id, 1);
    chk("bp_rsp1_sum",   bif.rsp_sum, 42);
    tick();

    // Reset during WAIT abandons the operation.
    bif.req_value_a[2] = 32'd9;
    bif.req_value_b[2] = 32'd9;
    bif.req_valid      = 4'b0100;
    #1 chk("rmid_grant", bif.req_ready, 4'b0100);
    tick();
    bif.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("rmid_rsp_valid", bif.rsp_valid, 0);
    chk("rmid_rsp_id",    bif.rsp_id, 0);
    chk("rmid_rsp_sum",   bif.rsp_sum, 0);
    chk("rmid_rsp_ovf",   bif.rsp_overflow, 0);
    chk("rmid_op_a",      bif.adder_value_a, 0);
    chk("rmid_op_b",      bif.adder_value_b, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmid_no_rsp", bif.rsp_valid, 0);
    end

    // Round-robin with all requesters pending: 0,1,2,3,0 every 4 cycles.
    for (int i = 0; i < R; i++) begin
      bif.req_value_a[i] = W'((i + 1) * 16);
      bif.req_value_b[i] = 32'd100;
    end
    bif.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] id;
      id = 2'(k % R);
      #1 chk("rr_grant", bif.req_ready, onehot(id));
      tick();
      chk("rr_op_a", bif.adder_value_a, 32'((k % R + 1) * 16));
      tick(); tick();
      chk("rr_rsp_valid", bif.rsp_valid, 1);
      chk("rr_rsp_id",    bif.rsp_id, id);
      chk("rr_rsp_sum",   bif.rsp_sum, 32'((k % R + 1) * 16 + 100));
      tick();
    end
    bif.req_valid = '0;

    // ADDER_LATENCY=3: accept to response in 5 cycles.
    bif3.req_value_a[0] = 32'd100;
    bif3.req_value_b[0] = 32'd23;
    bif3.req_valid      = 4'b0001;
    #1 chk("l3_grant", bif3.req_ready, 4'b0001);
    tick();
    bif3.req_valid = '0;
    cyc = 1;
    while (!bif3.rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("l3_latency", cyc, 5);
    chk("l3_rsp_sum", bif3.rsp_sum, 123);
    chk("l3_rsp_id",  bif3.rsp_id, 0);
    tick();
    chk("l3_idle", bif3.rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
